// File: rtl/multi_mode_clock.sv
// multi_mode_clock: 24-hour time-of-day keeper with a set FSM, external load and 12/24-hour BCD digits.
// Define CLOCK_SECONDS_EN to include the seconds counter; without it time advances once per minute.
module multi_mode_clock #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode24,
    input  logic       pulsed_set,
    input  logic       pulsed_up,
    input  logic       pulsed_down,
    input  logic       load,
    input  logic [4:0] load_hours,
    input  logic [5:0] load_minutes,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       is_pm,
    output logic [3:0] bcd_h1,
    output logic [3:0] bcd_h0,
    output logic [3:0] bcd_m1,
    output logic [3:0] bcd_m0,
    output logic [3:0] bcd_s1,
    output logic [3:0] bcd_s0,
    output logic [1:0] state,
    output logic       blink
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

`ifdef CLOCK_SECONDS_EN
    localparam longint PRE_TOP = longint'(TICK_DIV);
`else
    localparam longint PRE_TOP = 60 * longint'(TICK_DIV);
`endif
    localparam int PW = $clog2(PRE_TOP);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_TOP - 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t          state_q, next_state;
    logic [4:0]      hours_q, edit_h, src_h, disp_h;
    logic [5:0]      minutes_q, edit_m, src_m;
    logic [PW-1:0]   pre_q;
    logic [BW-1:0]   blink_cnt;
    logic            blink_q, commit, load_ok, step, tick, minute_carry;

    always_comb begin
        next_state = state_q;
        commit     = 1'b0;
        case (state_q)
            RUN:     if (pulsed_set) next_state = SET_HR;
            SET_HR:  if (pulsed_set) next_state = SET_MIN;
            SET_MIN: if (pulsed_set) begin
                next_state = RUN;
                commit     = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    assign load_ok = load && (state_q == RUN) && (load_hours <= 5'd23) && (load_minutes <= 6'd59);
    assign step    = (pulsed_up ^ pulsed_down) && !pulsed_set;
    assign tick    = (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= next_state;
    end

`ifdef CLOCK_SECONDS_EN
    logic [5:0] seconds_q;
    assign minute_carry = tick && (seconds_q == 6'd59);

    always_ff @(posedge clk) begin
        if (reset || commit || load_ok) seconds_q <= '0;
        else if (tick)                  seconds_q <= (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
    end

    assign seconds          = seconds_q;
    assign {bcd_s1, bcd_s0} = to_bcd(seconds_q);
`else
    assign minute_carry     = tick;
    assign seconds          = '0;
    assign {bcd_s1, bcd_s0} = 8'd0;
`endif

    // Commit and load both restart the prescaler, so any tick landing on that edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            hours_q   <= '0;
            minutes_q <= '0;
            pre_q     <= '0;
        end else if (commit) begin
            hours_q   <= edit_h;
            minutes_q <= edit_m;
            pre_q     <= '0;
        end else if (load_ok) begin
            hours_q   <= load_hours;
            minutes_q <= load_minutes;
            pre_q     <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (minute_carry) begin
                if (minutes_q == 6'd59) begin
                    minutes_q <= '0;
                    hours_q   <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_q <= minutes_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_h <= '0;
            edit_m <= '0;
        end else if (state_q == RUN && pulsed_set) begin
            edit_h <= hours_q;
            edit_m <= minutes_q;
        end else if (step && state_q == SET_HR) begin
            if (pulsed_up) edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
            else           edit_h <= (edit_h == 5'd0) ? 5'd23 : edit_h - 5'd1;
        end else if (step && state_q == SET_MIN) begin
            if (pulsed_up) edit_m <= (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
            else           edit_m <= (edit_m == 6'd0) ? 6'd59 : edit_m - 6'd1;
        end
    end

    // Blink phase restarts from 0 whenever the state changes and is held low in RUN.
    always_ff @(posedge clk) begin
        if (reset || next_state != state_q || state_q == RUN) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        src_h  = (state_q == RUN) ? hours_q : edit_h;
        src_m  = (state_q == RUN) ? minutes_q : edit_m;
        disp_h = src_h;
        if (!mode24) begin
            if (src_h == 5'd0)       disp_h = 5'd12;
            else if (src_h > 5'd12)  disp_h = src_h - 5'd12;
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign is_pm            = (src_h >= 5'd12);
    assign {bcd_h1, bcd_h0} = to_bcd({1'b0, disp_h});
    assign {bcd_m1, bcd_m0} = to_bcd(src_m);
    assign hours            = hours_q;
    assign minutes          = minutes_q;
    assign state            = state_q;
    assign blink            = blink_q;
endmodule

// File: tb/tb_multi_mode_clock.sv
// Self-checking bench for multi_mode_clock: directed scenarios plus random pulses against a
// seconds-of-day reference model.
module tb_multi_mode_clock;
    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;
`ifdef CLOCK_SECONDS_EN
    localparam int PERIOD = TICK_DIV;
    localparam int SPT    = 1;
`else
    localparam int PERIOD = 60 * TICK_DIV;
    localparam int SPT    = 60;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0, mode24 = 1'b1, pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_minutes = '0;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       is_pm, blink;
    logic [3:0] bcd_h1, bcd_h0, bcd_m1, bcd_m0, bcd_s1, bcd_s0;
    logic [1:0] state;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: time as seconds-of-day, cycles since last resync, edit values, state age.
    int m_tod = 0, m_cnt = 0, m_st = 0, m_eh = 0, m_em = 0, m_since = 0;

    multi_mode_clock #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .mode24(mode24), .pulsed_set(pulsed_set),
        .pulsed_up(pulsed_up), .pulsed_down(pulsed_down), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes), .hours(hours),
        .minutes(minutes), .seconds(seconds), .is_pm(is_pm), .bcd_h1(bcd_h1),
        .bcd_h0(bcd_h0), .bcd_m1(bcd_m1), .bcd_m0(bcd_m0), .bcd_s1(bcd_s1),
        .bcd_s0(bcd_s0), .state(state), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, expv);
        end
    endtask

    task automatic model_step(input bit rst, set, up, dn, ld, input int lh, lm);
        int nst;
        if (rst) begin
            m_tod = 0; m_cnt = 0; m_st = 0; m_eh = 0; m_em = 0; m_since = 0;
        end else begin
            nst = set ? (m_st + 1) % 3 : m_st;
            if (m_st == 0 && set) begin
                m_eh = m_tod / 3600;
                m_em = (m_tod / 60) % 60;
            end else if (!set && up != dn) begin
                if (m_st == 1) m_eh = (m_eh + (up ? 1 : 23)) % 24;
                if (m_st == 2) m_em = (m_em + (up ? 1 : 59)) % 60;
            end
            if (m_st == 2 && set) begin
                m_tod = m_eh * 3600 + m_em * 60;
                m_cnt = 0;
            end else if (m_st == 0 && ld && lh < 24 && lm < 60) begin
                m_tod = lh * 3600 + lm * 60;
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == PERIOD) begin
                    m_cnt = 0;
                    m_tod = (m_tod + SPT) % 86400;
                end
            end
            m_since = (nst != m_st) ? 0 : m_since + 1;
            m_st = nst;
        end
    endtask

    task automatic checkOutput(input string tag);
        int lh, lm, ls, sh, sm, dh;
        lh = m_tod / 3600;
        lm = (m_tod / 60) % 60;
        ls = m_tod % 60;
        sh = (m_st == 0) ? lh : m_eh;
        sm = (m_st == 0) ? lm : m_em;
        dh = mode24 ? sh : (sh == 0 ? 12 : (sh > 12 ? sh - 12 : sh));
        check_val({tag, "/hours"}, hours, lh);
        check_val({tag, "/minutes"}, minutes, lm);
        check_val({tag, "/seconds"}, seconds, ls);
        check_val({tag, "/state"}, state, m_st);
        check_val({tag, "/blink"}, blink, (m_st == 0) ? 0 : (m_since / BLINK_DIV) % 2);
        check_val({tag, "/is_pm"}, is_pm, (sh >= 12) ? 1 : 0);
        check_val({tag, "/bcd_h1"}, bcd_h1, dh / 10);
        check_val({tag, "/bcd_h0"}, bcd_h0, dh % 10);
        check_val({tag, "/bcd_m1"}, bcd_m1, sm / 10);
        check_val({tag, "/bcd_m0"}, bcd_m0, sm % 10);
        check_val({tag, "/bcd_s1"}, bcd_s1, ls / 10);
        check_val({tag, "/bcd_s0"}, bcd_s0, ls % 10);
    endtask

    task automatic applyStimulus(input string tag, input bit rst, set, up, dn, ld, input int lh, lm);
        reset = rst; pulsed_set = set; pulsed_up = up; pulsed_down = dn; load = ld;
        load_hours = 5'(lh); load_minutes = 6'(lm);
        @(posedge clk);
        model_step(rst, set, up, dn, ld, lh, lm);
        #1;
        reset = 1'b0; pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0; load = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and basic load behaviour
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0);
        check_val("reset_state", state, 0);
        check_val("reset_hours", hours, 0);
        applyStimulus("load1234", 0, 0, 0, 0, 1, 12, 34);
        check_val("load_h", hours, 12);
        check_val("load_m", minutes, 34);
        check_val("load_s", seconds, 0);
        applyStimulus("load2410", 0, 0, 0, 0, 1, 24, 10);
        check_val("bad_load_h", hours, 12);
        check_val("bad_load_m", minutes, 34);

        // 12-hour mapping
        applyStimulus("load1300", 0, 0, 0, 0, 1, 13, 0);
        mode24 = 1'b0; #1; checkOutput("mode12");
        check_val("pm13_h1", bcd_h1, 0);
        check_val("pm13_h0", bcd_h0, 1);
        check_val("pm13_is_pm", is_pm, 1);
        applyStimulus("load0000", 0, 0, 0, 0, 1, 0, 0);
        check_val("am12_h1", bcd_h1, 1);
        check_val("am12_h0", bcd_h0, 2);
        check_val("am12_is_pm", is_pm, 0);

        // Set sequence with wrap of edit fields
        applyStimulus("set_hr", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("down_hr", 0, 0, 0, 1, 0, 0, 0);
        check_val("edit_h23_h0", bcd_h0, 1);
        check_val("edit_h23_pm", is_pm, 1);
        applyStimulus("set_min", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("down_min", 0, 0, 0, 1, 0, 0, 0);
        check_val("edit_m59_m1", bcd_m1, 5);
        applyStimulus("up_min", 0, 0, 1, 0, 0, 0, 0);
        check_val("edit_m0_m0", bcd_m0, 0);
        applyStimulus("commit", 0, 1, 0, 0, 0, 0, 0);
        check_val("commit_h", hours, 23);
        check_val("commit_m", minutes, 0);
        check_val("commit_s", seconds, 0);
        check_val("commit_state", state, 0);

        // Load ignored outside RUN
        applyStimulus("set_hr2", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("load_in_set", 0, 0, 0, 0, 1, 5, 5);
        check_val("set_load_h", hours, 23);
        check_val("set_load_state", state, 1);
        applyStimulus("set_min2", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("commit2", 0, 1, 0, 0, 0, 0, 0);

        // up+down together leaves the edit unchanged
        mode24 = 1'b1;
        applyStimulus("set_hr3", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("updown", 0, 0, 1, 1, 0, 0, 0);
        check_val("updown_h1", bcd_h1, 2);
        check_val("updown_h0", bcd_h0, 3);
        applyStimulus("set_min3", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("up_min3", 0, 0, 1, 0, 0, 0, 0);

        // Commit landing on the tick edge discards the tick
        for (int i = 0; i < PERIOD && m_cnt != PERIOD - 1; i++) idle(1);
        check_val("pre_tick_align", m_cnt, PERIOD - 1);
        applyStimulus("commit_tick", 0, 1, 0, 0, 0, 0, 0);
        check_val("ctick_h", hours, 23);
        check_val("ctick_m", minutes, 1);
        check_val("ctick_s", seconds, 0);

        // Reset mid-edit discards edits
        applyStimulus("set_hr4", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("up4a", 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("up4b", 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("reset_mid", 1, 0, 0, 0, 0, 0, 0);
        check_val("rmid_state", state, 0);
        check_val("rmid_h", hours, 0);
        check_val("rmid_m", minutes, 0);

        // Blink cadence
        applyStimulus("set_blink", 0, 1, 0, 0, 0, 0, 0);
        check_val("blink_enter", blink, 0);
        idle(BLINK_DIV);
        check_val("blink_toggle", blink, 1);
        idle(2 * BLINK_DIV + 1);
        applyStimulus("blink_min", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("blink_run", 0, 1, 0, 0, 0, 0, 0);
        check_val("blink_run", blink, 0);

        // Day wrap from 23:59
        applyStimulus("load2359", 0, 0, 0, 0, 1, 23, 59);
        idle(239);
        check_val("prewrap_h", hours, 23);
        check_val("prewrap_m", minutes, 59);
        idle(1);
        check_val("wrap_h", hours, 0);
        check_val("wrap_m", minutes, 0);
        check_val("wrap_s", seconds, 0);

        // Random pulses against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mode24 = ~mode24;
                #1 checkOutput("rand_mode");
            end
            applyStimulus("rand", $urandom_range(0, 599) == 0, $urandom_range(0, 99) < 5,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 29) == 0, $urandom_range(0, 31), $urandom_range(0, 63));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
